pc_sequencer: RTL and testbench

- Program-counter and run-control sequencer for the 9-bit-instruction core.
- Consumes the jump controls from the instruction decoder (pc_jmp_en, pc_jmp_abs, 4-bit LUT pointer) and owns the 16-entry jump-target LUT.
- Handles start/done handshaking, data-memory stalls for load/store instructions, halt detection and cycle counting.
- Sits between the instruction ROM address port and the decoder; its commit output gates register-file and data-memory writes.

---
 rtl/pc_sequencer.sv | 138 +++++++++++++
 tb/tb_pc_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, jump-target LUT and run control for the
// 9-bit-instruction core. Handles the start/done handshake, data-memory
// stalls, halt detection and cycle/stall counting.
//
// state | meaning
// IDLE  | after reset; LUT writable, waiting for start
// RUN   | executing; pc advances on every commit
// DONE  | halted; done held, LUT writable, waiting for start
module pc_sequencer #(
    parameter int             PC_W    = 10,
    parameter logic [8:0]     HALT_OP = 9'h1FF,
    parameter int             CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PC_W-1:0]   prog_base,
    input  logic [8:0]        instr,
    input  logic              pc_jmp_en,
    input  logic              pc_jmp_abs,
    input  logic [3:0]        lut_ptr,
    input  logic              mem_access,
    input  logic              mem_ready,
    input  logic              lut_wr_en,
    input  logic [3:0]        lut_wr_addr,
    input  logic [PC_W-1:0]   lut_wr_data,
    output logic [PC_W-1:0]   pc,
    output logic              commit,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [PC_W-1:0]    lut_q [16];
    logic [PC_W-1:0]    lut_d [16];

    logic               run;
    logic               halt;
    logic               stall;
    logic [PC_W-1:0]    lut_rd;

    // Per-cycle run decode; halt outranks stall and jump, reset suppresses retire.
    always_comb begin
        run    = (state_q == ST_RUN);
        halt   = run && (instr == HALT_OP);
        stall  = run && mem_access && !mem_ready && !halt;
        commit = run && !halt && !stall && !reset;
        lut_rd = lut_q[lut_ptr];
    end

    // Next-state, pc, counter and LUT update.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        done_d      = done_q;
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        lut_d       = lut_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (lut_wr_en) begin
                    lut_d[lut_wr_addr] = lut_wr_data;
                end
                if (start) begin
                    state_d     = ST_RUN;
                    pc_d        = prog_base;
                    done_d      = 1'b0;
                    cycle_cnt_d = '0;
                    stall_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (cycle_cnt_q != {CNT_W{1'b1}}) begin
                    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                end
                if (halt) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (stall) begin
                    if (stall_cnt_q != {CNT_W{1'b1}}) begin
                        stall_cnt_d = stall_cnt_q + CNT_W'(1);
                    end
                end else if (pc_jmp_en && pc_jmp_abs) begin
                    pc_d = lut_rd;
                end else if (pc_jmp_en) begin
                    // Two's-complement add: unsigned modulo sum equals signed offset.
                    pc_d = pc_q + lut_rd;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            done_q      <= 1'b0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < 16; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            done_q      <= done_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            lut_q       <= lut_d;
        end
    end

    // Output drive.
    always_comb begin
        pc        = pc_q;
        busy      = run;
        done      = done_q;
        cycle_cnt = cycle_cnt_q;
        stall_cnt = stall_cnt_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  prog_base;
    logic [8:0]  instr;
    logic        pc_jmp_en;
    logic        pc_jmp_abs;
    logic [3:0]  lut_ptr;
    logic        mem_access;
    logic        mem_ready;
    logic        lut_wr_en;
    logic [3:0]  lut_wr_addr;
    logic [9:0]  lut_wr_data;
    logic [9:0]  pc;
    logic        commit;
    logic        busy;
    logic        done;
    logic [15:0] cycle_cnt;
    logic [15:0] stall_cnt;

    typedef struct packed {
        logic [9:0]  pc;
        logic        commit;
        logic        busy;
        logic        done;
        logic [15:0] cc;
        logic [15:0] sc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .prog_base  (prog_base),
        .instr      (instr),
        .pc_jmp_en  (pc_jmp_en),
        .pc_jmp_abs (pc_jmp_abs),
        .lut_ptr    (lut_ptr),
        .mem_access (mem_access),
        .mem_ready  (mem_ready),
        .lut_wr_en  (lut_wr_en),
        .lut_wr_addr(lut_wr_addr),
        .lut_wr_data(lut_wr_data),
        .pc         (pc),
        .commit     (commit),
        .busy       (busy),
        .done       (done),
        .cycle_cnt  (cycle_cnt),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cycle %0d %s: got %0h expected %0h", cyc_no, name, act, exp);
        end
    endtask

    // Monitor: pops the expectation for the current cycle, away from the clock edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pc",        int'(pc),        int'(e.pc));
            chk("commit",    int'(commit),    int'(e.commit));
            chk("busy",      int'(busy),      int'(e.busy));
            chk("done",      int'(done),      int'(e.done));
            chk("cycle_cnt", int'(cycle_cnt), int'(e.cc));
            chk("stall_cnt", int'(stall_cnt), int'(e.sc));
            cyc_no++;
        end
    end

    task automatic clr();
        reset = 0; start = 0; prog_base = '0; instr = '0;
        pc_jmp_en = 0; pc_jmp_abs = 0; lut_ptr = '0;
        mem_access = 0; mem_ready = 0;
        lut_wr_en = 0; lut_wr_addr = '0; lut_wr_data = '0;
    endtask

    // Push the expected outputs for the cycle whose inputs are now applied, then advance.
    task automatic tick(input logic [9:0] epc, input logic ecm, input logic ebz,
                        input logic edn, input logic [15:0] ecc, input logic [15:0] esc);
        exp_t e;
        e = '{pc: epc, commit: ecm, busy: ebz, done: edn, cc: ecc, sc: esc};
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic lut_write(input logic [3:0] a, input logic [9:0] d);
        clr(); lut_wr_en = 1; lut_wr_addr = a; lut_wr_data = d;
        tick(10'd0, 0, 0, 0, 16'd0, 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        reset = 1;
        @(posedge clk); #1;
        clr();
        // reset state
        tick(10'd0, 0, 0, 0, 16'd0, 16'd0);

        lut_write(4'd3, 10'h3FE);
        lut_write(4'd4, 10'd100);
        lut_write(4'd5, 10'd2);
        lut_write(4'd8, 10'h3FF);

        clr(); start = 1; prog_base = 10'd5;
        tick(10'd0, 0, 0, 0, 16'd0, 16'd0);

        // sequential execution 5..20
        clr();
        for (int k = 0; k < 15; k++) begin
            tick(10'(5 + k), 1, 1, 0, 16'(k), 16'd0);
        end

        // relative jump -2 at pc=20
        clr(); pc_jmp_en = 1; pc_jmp_abs = 0; lut_ptr = 4'd3;
        tick(10'd20, 1, 1, 0, 16'd15, 16'd0);
        // absolute jump to 100 at pc=18
        clr(); pc_jmp_en = 1; pc_jmp_abs = 1; lut_ptr = 4'd4;
        tick(10'd18, 1, 1, 0, 16'd16, 16'd0);

        // two stall cycles with a jump request that must be ignored
        clr(); mem_access = 1; mem_ready = 0; pc_jmp_en = 1; pc_jmp_abs = 1; lut_ptr = 4'd8;
        tick(10'd100, 0, 1, 0, 16'd17, 16'd0);
        tick(10'd100, 0, 1, 0, 16'd18, 16'd1);
        clr(); mem_access = 1; mem_ready = 1;
        tick(10'd100, 1, 1, 0, 16'd19, 16'd2);
        clr();
        tick(10'd101, 1, 1, 0, 16'd20, 16'd2);

        // halt beats jump and memory access
        clr(); instr = 9'h1FF; pc_jmp_en = 1; mem_access = 1; mem_ready = 0;
        tick(10'd102, 0, 1, 0, 16'd21, 16'd2);
        clr();
        tick(10'd102, 0, 0, 1, 16'd22, 16'd2);
        clr(); start = 1; prog_base = 10'd0;
        tick(10'd102, 0, 0, 1, 16'd22, 16'd2);

        // pc wrap: abs to 3FF, +1 -> 0, abs to 3FF, +2 -> 1
        clr(); pc_jmp_en = 1; pc_jmp_abs = 1; lut_ptr = 4'd8;
        tick(10'd0, 1, 1, 0, 16'd0, 16'd0);
        clr();
        tick(10'h3FF, 1, 1, 0, 16'd1, 16'd0);
        clr(); pc_jmp_en = 1; pc_jmp_abs = 1; lut_ptr = 4'd8;
        tick(10'd0, 1, 1, 0, 16'd2, 16'd0);
        clr(); pc_jmp_en = 1; pc_jmp_abs = 0; lut_ptr = 4'd5;
        tick(10'h3FF, 1, 1, 0, 16'd3, 16'd0);

        // LUT write during RUN is dropped: LUT[5] stays 2
        clr(); lut_wr_en = 1; lut_wr_addr = 4'd5; lut_wr_data = 10'h155;
        tick(10'd1, 1, 1, 0, 16'd4, 16'd0);
        clr(); pc_jmp_en = 1; pc_jmp_abs = 0; lut_ptr = 4'd5;
        tick(10'd2, 1, 1, 0, 16'd5, 16'd0);

        // reset mid-RUN: no commit in the reset cycle
        clr(); reset = 1; pc_jmp_en = 1; pc_jmp_abs = 1; lut_ptr = 4'd4;
        tick(10'd4, 0, 1, 0, 16'd6, 16'd0);
        clr();
        tick(10'd0, 0, 0, 0, 16'd0, 16'd0);
        clr(); start = 1; prog_base = 10'd50;
        tick(10'd0, 0, 0, 0, 16'd0, 16'd0);
        // LUT[5] cleared by reset: relative jump by 0 holds pc
        clr(); pc_jmp_en = 1; pc_jmp_abs = 0; lut_ptr = 4'd5;
        tick(10'd50, 1, 1, 0, 16'd0, 16'd0);
        clr();
        tick(10'd50, 1, 1, 0, 16'd1, 16'd0);
        tick(10'd51, 1, 1, 0, 16'd2, 16'd0);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
